// File: rtl/timer_bank_if.sv
// Register access bus for timer_bank: channel select, register address, write strobe/data, registered read data.
// Read data returns one cycle after sel/reg_addr are presented; there is no backpressure.
interface timer_bank_if #(
    parameter int CH_BITS = 2,
    parameter int M_BITS  = 32
);
    logic [CH_BITS-1:0] sel;
    logic [1:0]         reg_addr;
    logic               wr;
    logic [M_BITS-1:0]  wdata;
    logic [M_BITS-1:0]  rdata;

    modport master (output sel, reg_addr, wr, wdata, input rdata);
    modport slave  (input sel, reg_addr, wr, wdata, output rdata);
endinterface

// File: rtl/timer_bank.sv
// timer_bank: CH prescaled timer/counter channels; 1-cycle registered reads, writes always accepted, no backpressure.
// Define TIMER_BANK_IRQ_EN to add per-channel irq enable/pending bits (CTRL[5:4]) and the irq output.
module timer_bank #(
    parameter int CH      = 4,
    parameter int CH_BITS = 2,
    parameter int M_BITS  = 32,
    parameter int N_BITS  = 24
) (
    input  logic          clk,
    input  logic          reset_n,
    timer_bank_if.slave   bus,
    input  logic [CH-1:0] ext_tick,
    output logic [CH-1:0] done_tick,
    output logic [CH-1:0] of
`ifdef TIMER_BANK_IRQ_EN
    ,
    output logic          irq
`endif
);
    localparam logic [1:0] A_CTRL = 2'd0, A_M = 2'd1, A_CNT = 2'd2, A_LIM = 2'd3;

    logic [CH-1:0]     en;
    logic [1:0]        mode [CH];
    logic [M_BITS-1:0] m    [CH];
    logic [M_BITS-1:0] q    [CH];
    logic [N_BITS-1:0] cnt  [CH];
    logic [N_BITS-1:0] lim  [CH];
    logic [CH-1:0]     ext_q;
`ifdef TIMER_BANK_IRQ_EN
    logic [CH-1:0]     ien;
    logic [CH-1:0]     pend;
`endif

    logic [CH-1:0]     pre_run, pre_tick, evt, step, wrap_lim, wrap_max, wsel, clr;
    logic [M_BITS-1:0] rd_nxt;

    always_comb begin
        pre_run  = '0;
        pre_tick = '0;
        evt      = '0;
        step     = '0;
        wrap_lim = '0;
        wrap_max = '0;
        wsel     = '0;
        clr      = '0;
        for (int i = 0; i < CH; i++) begin
            wsel[i]     = bus.wr && (bus.sel == CH_BITS'(i));
            clr[i]      = wsel[i] && (bus.reg_addr == A_CTRL) && bus.wdata[3];
            pre_run[i]  = en[i] && !mode[i][1] && (m[i] != '0);
            pre_tick[i] = pre_run[i] && (q[i] == m[i] - M_BITS'(1));
            evt[i]      = en[i] && (mode[i] == 2'b10) && ext_tick[i] && !ext_q[i];
            // Clear has priority over a coincident count step.
            step[i]     = (pre_tick[i] || evt[i]) && !clr[i];
            wrap_lim[i] = (lim[i] != '0) && (cnt[i] == lim[i] - N_BITS'(1));
            // A limit at or below the counter is only honoured after a full-range wrap.
            wrap_max[i] = !wrap_lim[i] && (&cnt[i]);
        end
    end

    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < CH; i++) begin
            if (bus.sel == CH_BITS'(i)) begin
                case (bus.reg_addr)
                    A_CTRL: begin
                        rd_nxt[0]   = en[i];
                        rd_nxt[2:1] = mode[i];
`ifdef TIMER_BANK_IRQ_EN
                        rd_nxt[4]   = ien[i];
                        rd_nxt[5]   = pend[i];
`endif
                    end
                    A_M:     rd_nxt = m[i];
                    A_CNT:   rd_nxt[N_BITS:0]   = {of[i], cnt[i]};
                    default: rd_nxt[N_BITS-1:0] = lim[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en        <= '0;
            ext_q     <= '0;
            done_tick <= '0;
            of        <= '0;
            bus.rdata <= '0;
            for (int i = 0; i < CH; i++) begin
                mode[i] <= '0;
                m[i]    <= '0;
                q[i]    <= '0;
                cnt[i]  <= '0;
                lim[i]  <= '0;
            end
`ifdef TIMER_BANK_IRQ_EN
            ien  <= '0;
            pend <= '0;
            irq  <= 1'b0;
`endif
        end else begin
            ext_q     <= ext_tick;
            bus.rdata <= rd_nxt;
            for (int i = 0; i < CH; i++) begin
                done_tick[i] <= step[i] && (wrap_lim[i] || wrap_max[i]);
                if (clr[i]) begin
                    cnt[i] <= '0;
                    q[i]   <= '0;
                    of[i]  <= 1'b0;
                end else begin
                    if (pre_run[i])
                        q[i] <= pre_tick[i] ? '0 : q[i] + M_BITS'(1);
                    if (step[i]) begin
                        cnt[i] <= (wrap_lim[i] || wrap_max[i]) ? '0 : cnt[i] + N_BITS'(1);
                        if (wrap_max[i])
                            of[i] <= 1'b1;
                        if (wrap_lim[i] && mode[i] == 2'b01)
                            en[i] <= 1'b0;
                    end
                end
`ifdef TIMER_BANK_IRQ_EN
                if (step[i] && (wrap_lim[i] || wrap_max[i]))
                    pend[i] <= 1'b1;
                else if (wsel[i] && bus.reg_addr == A_CTRL && bus.wdata[5])
                    pend[i] <= 1'b0;
`endif
                // Register writes come last so a CTRL write overrides one-shot self-disable.
                if (wsel[i]) begin
                    case (bus.reg_addr)
                        A_CTRL: begin
                            en[i]   <= bus.wdata[0];
                            mode[i] <= bus.wdata[2:1];
`ifdef TIMER_BANK_IRQ_EN
                            ien[i]  <= bus.wdata[4];
`endif
                        end
                        A_M: begin
                            m[i] <= bus.wdata;
                            q[i] <= '0;
                        end
                        A_LIM:   lim[i] <= bus.wdata[N_BITS-1:0];
                        default: ;
                    endcase
                end
            end
`ifdef TIMER_BANK_IRQ_EN
            irq <= |(pend & ien);
`endif
        end
    end
endmodule
